// File: rtl/rect_fill_queue.sv
// rect_fill_queue
//   Queues filled-rectangle draw commands and issues them one at a time to
//   screen_writer. Each command is clipped against the screen when it is
//   popped from the FIFO. A command whose y origin is below the last legal
//   line is discarded without ever starting the writer.
//
//   Optional feature: define RECT_XOR_EN to build XOR fills. With it, a
//   command with cmd_xor=1 draws colour ^ old_screen_colour.
//
//   Handshake: a command is transferred on any rising clock edge where
//   cmd_valid && cmd_ready. cmd_ready depends only on reset and the FIFO
//   fill level, never on cmd_valid. The producer holds its data stable while
//   valid is high and ready is low.
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_x, cmd_y           top-left corner
//   cmd_w, cmd_h           size minus one
//   cmd_colour, cmd_xor    fill colour, XOR-fill request
//   screen_start           one-cycle start pulse to the writer
//   screen_x_min/y_min     clipped box origin
//   screen_x/y_range       clipped box extent minus one
//   new_screen_colour      colour for the pixel being written
//   screen_x, screen_y     writer pixel position (unused)
//   old_screen_colour      existing pixel colour (XOR mode only)
//   screen_done            writer finished the box
//   busy                   registered: FSM active or FIFO non-empty
//   fsm_state              current FSM state (IDLE=0, ISSUE=1, DRAW=2)
module rect_fill_queue #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int DEPTH        = 4,
  parameter int Y_LIMIT      = 239
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_x,
  input  logic [WIDTH-1:0]        cmd_y,
  input  logic [WIDTH-1:0]        cmd_w,
  input  logic [WIDTH-1:0]        cmd_h,
  input  logic [COLOUR_WIDTH-1:0] cmd_colour,
  input  logic                    cmd_xor,
  output logic                    screen_start,
  output logic [WIDTH-1:0]        screen_x_min,
  output logic [WIDTH-1:0]        screen_y_min,
  output logic [WIDTH-1:0]        screen_x_range,
  output logic [WIDTH-1:0]        screen_y_range,
  output logic [COLOUR_WIDTH-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]        screen_x,
  input  logic [WIDTH-1:0]        screen_y,
  input  logic [COLOUR_WIDTH-1:0] old_screen_colour,
  input  logic                    screen_done,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
`ifdef RECT_XOR_EN
  localparam int EW = 4 * WIDTH + COLOUR_WIDTH + 1;
`else
  localparam int EW = 4 * WIDTH + COLOUR_WIDTH;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;

  localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(Y_LIMIT);
  localparam logic [WIDTH-1:0] X_MAX = {WIDTH{1'b1}};

  // FIFO storage; DEPTH is a power of two so the pointers wrap by themselves.
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             push;
  logic             pop;
  logic [EW-1:0]    push_entry;

  logic [WIDTH-1:0]        head_x;
  logic [WIDTH-1:0]        head_y;
  logic [WIDTH-1:0]        head_w;
  logic [WIDTH-1:0]        head_h;
  logic [COLOUR_WIDTH-1:0] head_colour;
  logic [COLOUR_WIDTH-1:0] colour_q;

`ifdef RECT_XOR_EN
  logic head_xor;
  logic xor_q;
  assign push_entry = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, cmd_xor};
  assign {head_x, head_y, head_w, head_h, head_colour, head_xor} = mem[rd_ptr];
  logic unused_inputs;
  assign unused_inputs = ^{screen_x, screen_y};
`else
  assign push_entry = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};
  assign {head_x, head_y, head_w, head_h, head_colour} = mem[rd_ptr];
  logic unused_inputs;
  assign unused_inputs = ^{screen_x, screen_y, cmd_xor, old_screen_colour};
`endif

  assign cmd_ready    = !reset && (count < CNT_W'(DEPTH));
  assign push         = cmd_valid && cmd_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign screen_start = (state == ISSUE);
  assign fsm_state    = state;

  // Clipping: take the room left to the screen edge first (never negative
  // because the origin is checked against the limit), then the smaller of
  // room and requested extent. Nothing here can wrap.
  logic [WIDTH-1:0] x_room;
  logic [WIDTH-1:0] y_room;
  logic [WIDTH-1:0] x_clip;
  logic [WIDTH-1:0] y_clip;
  logic             y_drop;

  always_comb begin
    x_room = X_MAX - head_x;
    x_clip = (head_w > x_room) ? x_room : head_w;
    y_drop = (head_y > Y_MAX);
    y_room = y_drop ? '0 : (Y_MAX - head_y);
    y_clip = (head_h > y_room) ? y_room : head_h;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      state          <= IDLE;
      screen_x_min   <= '0;
      screen_y_min   <= '0;
      screen_x_range <= '0;
      screen_y_range <= '0;
      colour_q       <= '0;
`ifdef RECT_XOR_EN
      xor_q          <= 1'b0;
`endif
      busy           <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Registered from the current cycle, so it drops one cycle after the
      // final DRAW->IDLE transition.
      busy <= (state != IDLE) || (count != '0);

      case (state)
        IDLE: begin
          // A dropped command is consumed here but leaves the box untouched.
          if (pop && !y_drop) begin
            screen_x_min   <= head_x;
            screen_y_min   <= head_y;
            screen_x_range <= x_clip;
            screen_y_range <= y_clip;
            colour_q       <= head_colour;
`ifdef RECT_XOR_EN
            xor_q          <= head_xor;
`endif
            state          <= ISSUE;
          end
        end
        ISSUE:   state <= DRAW;
        DRAW:    if (screen_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
`ifdef RECT_XOR_EN
    new_screen_colour = xor_q ? (colour_q ^ old_screen_colour) : colour_q;
`else
    new_screen_colour = colour_q;
`endif
  end

endmodule

// File: tb/tb_rect_fill_queue.sv
// tb_rect_fill_queue
//   Bench for rect_fill_queue with a behavioural screen_writer and a
//   reference model that predicts each issued box from the raw command.
module tb_rect_fill_queue;

  localparam int WIDTH   = 8;
  localparam int CW      = 3;
  localparam int DEPTH   = 4;
  localparam int Y_LIMIT = 239;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [CW-1:0]    col;
    logic             xo;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [CW-1:0]    cmd_colour = '0;
  logic             cmd_xor = 1'b0;
  logic             screen_start;
  logic [WIDTH-1:0] screen_x_min, screen_y_min, screen_x_range, screen_y_range;
  logic [CW-1:0]    new_screen_colour;
  logic [WIDTH-1:0] screen_x = '0, screen_y = '0;
  logic [CW-1:0]    old_screen_colour = '0;
  logic             screen_done = 1'b0;
  logic             busy;
  logic [1:0]       fsm_state;

  int checks = 0;
  int failures = 0;

  logic [EXP_W-1:0] exp_q[$];

  // writer model state
  logic stall = 1'b0;
  logic random_old = 1'b1;
  logic pending = 1'b0;
  int   remaining = 0;
  int   ncyc = 0;
  int   last_done_n = -100;
  int   starts = 0;
  exp_t cur;
  exp_t last_box;
  logic [CW-1:0] last_colour = '0;

  rect_fill_queue #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW), .DEPTH(DEPTH), .Y_LIMIT(Y_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour), .cmd_xor(cmd_xor),
    .screen_start(screen_start),
    .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
    .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
    .new_screen_colour(new_screen_colour),
    .screen_x(screen_x), .screen_y(screen_y),
    .old_screen_colour(old_screen_colour),
    .screen_done(screen_done), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model
  function automatic logic [CW-1:0] exp_colour(input logic [CW-1:0] col, input logic xo,
                                               input logic [CW-1:0] old);
`ifdef RECT_XOR_EN
    return xo ? (col ^ old) : col;
`else
    return col;
`endif
  endfunction

  task automatic model_push(input int x, input int y, input int w, input int h,
                            input int col, input int xo);
    exp_t e;
    int room;
    if (y > Y_LIMIT) return;
    room = 255 - x;
    e.x   = WIDTH'(x);
    e.y   = WIDTH'(y);
    e.xr  = WIDTH'((w < room) ? w : room);
    room  = Y_LIMIT - y;
    e.yr  = WIDTH'((h < room) ? h : room);
    e.col = CW'(col);
    e.xo  = xo[0];
    exp_q.push_back(EXP_W'(e));
  endtask

  // writer model + scoreboard
  initial begin
    forever begin
      @(negedge clock);
      ncyc++;
      if (!reset) begin
        if (screen_start) begin
          checks++;
          if (pending) begin
            failures++;
            $display("FAIL start_during_draw got=1 exp=0 cycle=%0d", ncyc);
          end
          checks++;
          if (ncyc - last_done_n < 2) begin
            failures++;
            $display("FAIL start_spacing got=%0d exp>=2", ncyc - last_done_n);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_start got=start exp=none");
            cur = '{screen_x_min, screen_y_min, screen_x_range, screen_y_range, 3'd0, 1'b0};
          end else begin
            cur = exp_t'(exp_q.pop_front());
            checks++;
            if ({screen_x_min, screen_y_min, screen_x_range, screen_y_range} !==
                {cur.x, cur.y, cur.xr, cur.yr}) begin
              failures++;
              $display("FAIL box got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                       screen_x_min, screen_y_min, screen_x_range, screen_y_range,
                       cur.x, cur.y, cur.xr, cur.yr);
            end
            checks++;
            if (new_screen_colour !== exp_colour(cur.col, cur.xo, old_screen_colour)) begin
              failures++;
              $display("FAIL colour got=%0d exp=%0d", new_screen_colour,
                       exp_colour(cur.col, cur.xo, old_screen_colour));
            end
          end
          last_box    = '{screen_x_min, screen_y_min, screen_x_range, screen_y_range, 3'd0, 1'b0};
          last_colour = new_screen_colour;
          starts++;
        end else if (pending) begin
          checks++;
          if ({screen_x_min, screen_y_min, screen_x_range, screen_y_range, new_screen_colour} !==
              {cur.x, cur.y, cur.xr, cur.yr, exp_colour(cur.col, cur.xo, old_screen_colour)}) begin
            failures++;
            $display("FAIL box_stable got=%0d/%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                     screen_x_min, screen_y_min, screen_x_range, screen_y_range,
                     new_screen_colour, cur.x, cur.y, cur.xr, cur.yr);
          end
        end

        // writer progress
        if (screen_done) begin
          screen_done = 1'b0;
          pending     = 1'b0;
        end else if (pending && !stall) begin
          if (remaining == 0) begin
            screen_done = 1'b1;
            last_done_n = ncyc;
          end else begin
            remaining--;
          end
        end
        if (screen_start) begin
          pending   = 1'b1;
          remaining = $urandom_range(0, 4);
        end
        if (random_old) old_screen_colour = CW'($urandom);
      end
    end
  end

  // driver tasks
  task automatic push_cmd(input int x, input int y, input int w, input int h,
                          input int col, input int xo);
    int t = 0;
    cmd_x = WIDTH'(x); cmd_y = WIDTH'(y); cmd_w = WIDTH'(w); cmd_h = WIDTH'(h);
    cmd_colour = CW'(col); cmd_xor = xo[0];
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL push_timeout got=ready0 exp=ready1");
    end else begin
      model_push(x, y, w, h, col, xo);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    repeat (2) @(negedge clock);
    while ((busy || fsm_state != 2'd0) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (busy !== 1'b0 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL %s_idle got=busy%0d/state%0d exp=busy0/state0", name, busy, fsm_state);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({screen_start, screen_x_min, screen_y_min, screen_x_range, screen_y_range,
         new_screen_colour, busy, fsm_state} !== '0) begin
      failures++;
      $display("FAIL %s_zero got=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d exp=all0", name,
               screen_start, screen_x_min, screen_y_min, screen_x_range, screen_y_range,
               new_screen_colour, busy, fsm_state);
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low got=%0d exp=0", cmd_ready);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_high got=%0d exp=1", cmd_ready);
    end
  endtask

  task automatic test_single();
    int s0 = starts;
    push_cmd(10, 20, 3, 1, 5, 0);
    checks++;
    if (screen_start !== 1'b0) begin
      failures++;
      $display("FAIL single_early_start got=%0d exp=0", screen_start);
    end
    @(negedge clock);
    checks++;
    if ({screen_start, screen_x_min, screen_y_min, screen_x_range, screen_y_range,
         new_screen_colour} !== {1'b1, 8'd10, 8'd20, 8'd3, 8'd1, 3'd5}) begin
      failures++;
      $display("FAIL single_issue got=%0d/%0d/%0d/%0d/%0d/%0d exp=1/10/20/3/1/5",
               screen_start, screen_x_min, screen_y_min, screen_x_range, screen_y_range,
               new_screen_colour);
    end
    @(negedge clock);
    checks++;
    if (screen_start !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse_width got=%0d exp=0", screen_start);
    end
    wait_idle("single");
    checks++;
    if (starts != s0 + 1) begin
      failures++;
      $display("FAIL single_starts got=%0d exp=%0d", starts - s0, 1);
    end
  endtask

  task automatic test_fill();
    int s0 = starts;
    int acc = 0;
    int x, y, w, h, c, xo;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, 255); y = $urandom_range(0, Y_LIMIT);
      w = $urandom_range(0, 15);  h = $urandom_range(0, 15);
      c = $urandom_range(0, 7);   xo = $urandom_range(0, 1);
      cmd_x = WIDTH'(x); cmd_y = WIDTH'(y); cmd_w = WIDTH'(w); cmd_h = WIDTH'(h);
      cmd_colour = CW'(c); cmd_xor = xo[0];
      cmd_valid = 1'b1;
      if (cmd_ready) begin
        acc++;
        model_push(x, y, w, h, c, xo);
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    checks++;
    if (acc != 5) begin
      failures++;
      $display("FAIL fill_accepted got=%0d exp=5", acc);
    end
    checks++;
    if ({cmd_ready, busy, fsm_state} !== {1'b0, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL fill_full got=ready%0d/busy%0d/state%0d exp=ready0/busy1/state2",
               cmd_ready, busy, fsm_state);
    end
    checks++;
    if (starts != s0 + 1) begin
      failures++;
      $display("FAIL fill_stalled_starts got=%0d exp=1", starts - s0);
    end
    stall = 1'b0;
    wait_idle("fill");
    checks++;
    if (starts != s0 + 5 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_drained got=%0d/ready%0d exp=5/ready1", starts - s0, cmd_ready);
    end
  endtask

  task automatic test_clip();
    int s0;
    push_cmd(250, 5, 20, 2, 3, 0);
    wait_idle("clip_x");
    checks++;
    if ({last_box.xr, last_box.yr} !== {8'd5, 8'd2}) begin
      failures++;
      $display("FAIL clip_x got=%0d/%0d exp=5/2", last_box.xr, last_box.yr);
    end
    push_cmd(7, 230, 4, 50, 1, 0);
    wait_idle("clip_y");
    checks++;
    if ({last_box.xr, last_box.yr} !== {8'd4, 8'd9}) begin
      failures++;
      $display("FAIL clip_y got=%0d/%0d exp=4/9", last_box.xr, last_box.yr);
    end
    push_cmd(255, 239, 9, 9, 2, 0);
    wait_idle("clip_corner");
    checks++;
    if ({last_box.x, last_box.y, last_box.xr, last_box.yr} !== {8'd255, 8'd239, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL clip_corner got=%0d/%0d/%0d/%0d exp=255/239/0/0",
               last_box.x, last_box.y, last_box.xr, last_box.yr);
    end
    s0 = starts;
    push_cmd(3, 240, 2, 2, 6, 0);
    push_cmd(1, 2, 1, 1, 4, 0);
    wait_idle("clip_drop");
    checks++;
    if (starts != s0 + 1 || last_box.x !== 8'd1) begin
      failures++;
      $display("FAIL clip_drop got=%0d/x%0d exp=1/x1", starts - s0, last_box.x);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    stall = 1'b1;
    push_cmd(1, 1, 2, 2, 1, 0);
    push_cmd(2, 2, 2, 2, 2, 0);
    push_cmd(3, 3, 2, 2, 3, 0);
    checks++;
    if (fsm_state !== 2'd2 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup got=state%0d/ready%0d exp=state2/ready1", fsm_state, cmd_ready);
    end
    reset = 1'b1;
    pending = 1'b0;
    screen_done = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_outputs_zero("mid_reset");
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready got=%0d exp=1", cmd_ready);
    end
    stall = 1'b0;
    s0 = starts;
    repeat (20) @(negedge clock);
    checks++;
    if (starts != s0 || busy !== 1'b0 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_no_start got=%0d/busy%0d exp=0/busy0", starts - s0, busy);
    end
  endtask

  task automatic test_xor();
    logic [CW-1:0] want;
`ifdef RECT_XOR_EN
    want = 3'b101;
`else
    want = 3'b011;
`endif
    random_old = 1'b0;
    old_screen_colour = 3'b110;
    push_cmd(4, 4, 1, 1, 3, 1);
    wait_idle("xor");
    checks++;
    if (last_colour !== want) begin
      failures++;
      $display("FAIL xor_colour got=%0d exp=%0d", last_colour, want);
    end
    random_old = 1'b1;
  endtask

  task automatic test_random();
    int s0 = starts;
    int kept = 0;
    for (int i = 0; i < 40; i++) begin
      int y = $urandom_range(0, 255);
      if (y <= Y_LIMIT) kept++;
      push_cmd($urandom_range(0, 255), y, $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 7), $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle("random");
    checks++;
    if (starts != s0 + kept) begin
      failures++;
      $display("FAIL random_starts got=%0d exp=%0d", starts - s0, kept);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_fill();
    test_clip();
    test_reset_mid();
    test_xor();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
